// File: rtl/timing_interrupt_sequencer.sv
// Sequence counter, one-hot timing decode, IEN/R flags, halt state and
// prioritised multi-channel interrupt capture with per-channel vectoring.
module timing_interrupt_sequencer #(
    parameter int T_WIDTH       = 16,
    parameter int IRQ_CHANNELS  = 4,
    parameter int ADDR_WIDTH    = 12,
    parameter int VECTOR_BASE   = 0,
    parameter int VECTOR_STRIDE = 1,
    localparam int SCW = (T_WIDTH > 1) ? $clog2(T_WIDTH) : 1,
    localparam int IDW = (IRQ_CHANNELS > 1) ? $clog2(IRQ_CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    seq_clr,
    input  logic                    halt_req,
    input  logic                    resume,
    input  logic                    ion,
    input  logic                    iof,
    input  logic [IRQ_CHANNELS-1:0] irq_req,
    input  logic [IRQ_CHANNELS-1:0] irq_mask,
    output logic [T_WIDTH-1:0]      T,
    output logic [SCW-1:0]          sc_value,
    output logic                    R,
    output logic                    ien,
    output logic                    halted,
    output logic [IRQ_CHANNELS-1:0] irq_ack,
    output logic [IDW-1:0]          irq_id,
    output logic [ADDR_WIDTH-1:0]   vector_addr,
    output logic                    sc_overflow
);

    localparam logic [SCW-1:0] SC_LAST = SCW'(T_WIDTH - 1);

    logic [SCW-1:0]          sc;
    logic [IRQ_CHANNELS-1:0] pending;
    logic [IDW-1:0]          pick;
    logic                    t2;
    logic                    icycle;
    logic                    r_set;

    assign pending = irq_req & irq_mask;
    assign t2      = !halted && (sc == SCW'(2));
    // T0..T2 with R set is the interrupt cycle; seq_clr cannot cut it short.
    assign icycle  = R && (sc < SCW'(3));
    assign r_set   = !R && !halted && ien && (sc >= SCW'(3)) && (pending != '0);

    always_comb begin
        pick = '0;
        for (int i = IRQ_CHANNELS - 1; i >= 0; i--)
            if (pending[i]) pick = IDW'(i);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sc          <= '0;
            R           <= 1'b0;
            ien         <= 1'b0;
            halted      <= 1'b0;
            irq_id      <= '0;
            sc_overflow <= 1'b0;
        end else begin
            if (halted)
                sc <= '0;
            else if (R && t2)
                sc <= '0;
            else if (seq_clr && !icycle)
                sc <= '0;
            else if (halt_req && !R)
                sc <= '0;
            else if (sc == SC_LAST) begin
                sc          <= '0;
                sc_overflow <= 1'b1;
            end else
                sc <= sc + SCW'(1);

            if (halted) begin
                if (resume) halted <= 1'b0;
            end else if (halt_req && !R)
                halted <= 1'b1;

            if (R && t2)
                R <= 1'b0;
            else if (r_set) begin
                R      <= 1'b1;
                irq_id <= pick;
            end

            if (R && t2)
                ien <= 1'b0;
            else if (iof)
                ien <= 1'b0;
            else if (ion)
                ien <= 1'b1;
        end
    end

    assign sc_value    = sc;
    assign T           = halted ? '0 : ({{(T_WIDTH-1){1'b0}}, 1'b1} << sc);
    assign irq_ack     = (R && t2) ? ({{(IRQ_CHANNELS-1){1'b0}}, 1'b1} << irq_id) : '0;
    assign vector_addr = ADDR_WIDTH'(VECTOR_BASE)
                       + ADDR_WIDTH'(irq_id) * ADDR_WIDTH'(VECTOR_STRIDE);

endmodule
